display_scheduler: RTL and testbench

- Sequences which game value the 6-digit multiplexed display shows: player total, dealer total or round timer.
- Rotates between active sources on a dwell timer and accepts a manual "next" button.
- Lets a one-shot alert message (e.g. BUST/WIN code) pre-empt rotation and blink for a fixed time.
- Drives digit0..digit5 and showUpperBits of the downstream digit rotator.

---
 rtl/display_pkg.sv | 29 ++
 rtl/rr_next_src.sv | 43 ++++
 rtl/display_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_display_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the display scheduler slice.
//   - state_t     : scheduler state (IDLE / SHOW / ALERT)
//   - SRC_*       : source index encoding used on active_src
//   - BLANK_CODE  : digit value the digit decoder renders as all-segments-off
//   - digits_t    : six packed 4-bit digits, [3:0] = digit0
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;

    localparam logic [1:0] SRC_PLAYER = 2'd0;
    localparam logic [1:0] SRC_DEALER = 2'd1;
    localparam logic [1:0] SRC_TIMER  = 2'd2;
    localparam logic [1:0] SRC_NONE   = 2'd3;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [23:0] digits_t;

    // Replicates a single digit code across all six digit positions.
    function automatic digits_t fill_digits(input logic [3:0] code);
        return {6{code}};
    endfunction

endpackage

// File: rtl/rr_next_src.sv
// rr_next_src
//   Combinational round-robin finder over the three display sources.
//   Searches cur+1, cur+2, cur+3 (mod 3) and returns the first requester,
//   which may be cur itself when it is the only one asking.
//   Ports:
//     req [2:0] : source valid bits, [0] player, [1] dealer, [2] timer
//     cur [1:0] : current source; passing SRC_TIMER yields the lowest requester
//     nxt [1:0] : next source to show (equals cur when nothing requests)
//     any       : at least one source is requesting
module rr_next_src
    import display_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] cur,
    output logic [1:0] nxt,
    output logic       any
);

    // Search order is hard-coded per starting point; an out-of-range cur
    // behaves like SRC_TIMER so the search starts at the player.
    always_comb begin
        nxt = cur;
        any = |req;
        case (cur)
            SRC_PLAYER: begin
                if (req[1])      nxt = SRC_DEALER;
                else if (req[2]) nxt = SRC_TIMER;
                else if (req[0]) nxt = SRC_PLAYER;
            end
            SRC_DEALER: begin
                if (req[2])      nxt = SRC_TIMER;
                else if (req[0]) nxt = SRC_PLAYER;
                else if (req[1]) nxt = SRC_DEALER;
            end
            default: begin
                if (req[0])      nxt = SRC_PLAYER;
                else if (req[1]) nxt = SRC_DEALER;
                else if (req[2]) nxt = SRC_TIMER;
            end
        endcase
    end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
//   Chooses what the 6-digit multiplexed display shows: player total, dealer
//   total or round timer, rotating on a dwell timer or on a manual "next"
//   press. A one-shot alert message pre-empts rotation and blinks for a fixed
//   time before rotation resumes.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     req[2:0]            : source valid bits ([0] player, [1] dealer, [2] timer)
//     src0/1/2_digits     : live packed digits of each source ([3:0] = digit0)
//     next_btn            : pulse, advance to the next requesting source now
//     half_btn            : pulse, toggle showUpperBits
//     alert_req           : pulse, start (or restart) an alert
//     alert_digits        : alert message, captured on alert_req
//     digit0..digit5      : registered digits to the digit rotator
//     showUpperBits       : registered upper/lower half select
//     active_src          : source shown (saved source during an alert), 3 when idle
//     alert_active        : high while an alert is on screen
//   All outputs are registered from the next-state values, so any input is
//   visible on the outputs right after the edge that samples it.
module display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int unsigned ALERT_CYCLES = 200000000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter logic [3:0]  BLANK_CODE   = display_pkg::BLANK_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] src0_digits,
    input  logic [23:0] src1_digits,
    input  logic [23:0] src2_digits,
    input  logic        next_btn,
    input  logic        half_btn,
    input  logic        alert_req,
    input  logic [23:0] alert_digits,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [3:0]  digit5,
    output logic        showUpperBits,
    output logic [1:0]  active_src,
    output logic        alert_active
);

    import display_pkg::*;

    // Counters are sized to hold parameter-1 and saturate there by design.
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int AW = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    state_t        state, state_n;
    logic [1:0]    cur, cur_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [AW-1:0] alert_cnt, alert_cnt_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_on, blink_on_n;
    digits_t       alert_msg, alert_msg_n;

    digits_t       disp, disp_n;
    logic [1:0]    src_n;
    logic          alert_n;
    logic          upper;
    logic [1:0]    src_q;
    logic          alert_q;

    logic [1:0]    rr_cur;
    logic [1:0]    rr_nxt;
    logic          rr_any;
    logic          cur_req;

    // From IDLE the finder starts after the timer, which yields the
    // lowest-index requester; otherwise it rotates from the current source.
    assign rr_cur = (state == IDLE) ? SRC_TIMER : cur;

    rr_next_src u_rr (
        .req (req),
        .cur (rr_cur),
        .nxt (rr_nxt),
        .any (rr_any)
    );

    always_comb begin
        case (cur)
            SRC_PLAYER: cur_req = req[0];
            SRC_DEALER: cur_req = req[1];
            SRC_TIMER:  cur_req = req[2];
            default:    cur_req = 1'b0;
        endcase
    end

    // Next-state logic. alert_req overrides everything (including next_btn)
    // and leaves cur untouched, so cur doubles as the saved source.
    always_comb begin
        state_n     = state;
        cur_n       = cur;
        dwell_n     = dwell;
        alert_cnt_n = alert_cnt;
        blink_cnt_n = blink_cnt;
        blink_on_n  = blink_on;
        alert_msg_n = alert_msg;

        if (alert_req) begin
            state_n     = ALERT;
            alert_msg_n = alert_digits;
            alert_cnt_n = '0;
            blink_cnt_n = '0;
            blink_on_n  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        state_n = SHOW;
                        cur_n   = rr_nxt;
                        dwell_n = '0;
                    end
                end
                SHOW: begin
                    if (!rr_any) begin
                        state_n = IDLE;
                        dwell_n = '0;
                    end else if (!cur_req || next_btn || (dwell == DWELL_LAST)) begin
                        cur_n   = rr_nxt;
                        dwell_n = '0;
                    end else begin
                        dwell_n = dwell + DW'(1);
                    end
                end
                ALERT: begin
                    if (alert_cnt == ALERT_LAST) begin
                        dwell_n = '0;
                        if (cur_req) begin
                            state_n = SHOW;
                        end else if (rr_any) begin
                            state_n = SHOW;
                            cur_n   = rr_nxt;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        alert_cnt_n = alert_cnt + AW'(1);
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_n = '0;
                            blink_on_n  = ~blink_on;
                        end else begin
                            blink_cnt_n = blink_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Output values derived from the next state so they register on the
    // same edge as the state change.
    always_comb begin
        disp_n  = fill_digits(BLANK_CODE);
        src_n   = SRC_NONE;
        alert_n = 1'b0;
        case (state_n)
            SHOW: begin
                src_n = cur_n;
                case (cur_n)
                    SRC_PLAYER: disp_n = src0_digits;
                    SRC_DEALER: disp_n = src1_digits;
                    SRC_TIMER:  disp_n = src2_digits;
                    default:    disp_n = fill_digits(BLANK_CODE);
                endcase
            end
            ALERT: begin
                src_n   = cur_n;
                alert_n = 1'b1;
                disp_n  = blink_on_n ? alert_msg_n : fill_digits(BLANK_CODE);
            end
            default: begin
                disp_n  = fill_digits(BLANK_CODE);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= SRC_PLAYER;
            dwell     <= '0;
            alert_cnt <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            alert_msg <= '0;
            disp      <= fill_digits(BLANK_CODE);
            src_q     <= SRC_NONE;
            alert_q   <= 1'b0;
            upper     <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            dwell     <= dwell_n;
            alert_cnt <= alert_cnt_n;
            blink_cnt <= blink_cnt_n;
            blink_on  <= blink_on_n;
            alert_msg <= alert_msg_n;
            disp      <= disp_n;
            src_q     <= src_n;
            alert_q   <= alert_n;
            if (half_btn) begin
                upper <= ~upper;
            end
        end
    end

    assign digit0        = disp[3:0];
    assign digit1        = disp[7:4];
    assign digit2        = disp[11:8];
    assign digit3        = disp[15:12];
    assign digit4        = disp[19:16];
    assign digit5        = disp[23:20];
    assign showUpperBits = upper;
    assign active_src    = src_q;
    assign alert_active  = alert_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//   Self-checking bench for display_scheduler with short timing parameters.
//   Each driven cycle, a behavioural model predicts the post-edge outputs and
//   pushes them onto a scoreboard queue; after the edge the prediction is
//   popped and compared against the DUT. Scenario checkpoints add fixed
//   expectations worked out by hand.
module tb_display_scheduler;

    localparam int DWELL = 8;
    localparam int ALERTC = 16;
    localparam int BLINK = 4;

    typedef struct {
        logic [23:0] digits;
        logic [1:0]  src;
        logic        alert;
        logic        upper;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] src0_digits, src1_digits, src2_digits;
    logic        next_btn, half_btn, alert_req;
    logic [23:0] alert_digits;
    logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5;
    logic        showUpperBits;
    logic [1:0]  active_src;
    logic        alert_active;
    logic [23:0] dut_digits;

    int num_checks = 0;
    int num_fails  = 0;

    exp_t exp_q[$];

    // Reference model state
    int          m_state;   // 0 idle, 1 show, 2 alert
    int          m_cur;
    int          m_dwell;
    int          m_acnt;
    int          m_bcnt;
    bit          m_on;
    logic [23:0] m_msg;
    bit          m_half;

    display_scheduler #(
        .DWELL_CYCLES (DWELL),
        .ALERT_CYCLES (ALERTC),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .src0_digits   (src0_digits),
        .src1_digits   (src1_digits),
        .src2_digits   (src2_digits),
        .next_btn      (next_btn),
        .half_btn      (half_btn),
        .alert_req     (alert_req),
        .alert_digits  (alert_digits),
        .digit0        (digit0),
        .digit1        (digit1),
        .digit2        (digit2),
        .digit3        (digit3),
        .digit4        (digit4),
        .digit5        (digit5),
        .showUpperBits (showUpperBits),
        .active_src    (active_src),
        .alert_active  (alert_active)
    );

    assign dut_digits = {digit5, digit4, digit3, digit2, digit1, digit0};

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    // Round-robin search: first requester after c, wrapping, possibly c itself.
    function automatic int modelNext(input logic [2:0] r, input int c);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (c + k) % 3;
            if (r[i]) return i;
        end
        return c;
    endfunction

    function automatic int modelLowest(input logic [2:0] r);
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Advances the model by one clock using the inputs currently driven and
    // returns the outputs the DUT should present after that edge.
    task automatic modelStep(output exp_t e);
        if (rst) begin
            m_state = 0; m_cur = 0; m_dwell = 0; m_acnt = 0; m_bcnt = 0;
            m_on = 1'b0; m_msg = '0; m_half = 1'b0;
        end else begin
            if (half_btn) m_half = !m_half;
            if (alert_req) begin
                m_state = 2; m_msg = alert_digits; m_acnt = 0; m_bcnt = 0; m_on = 1'b1;
            end else if (m_state == 0) begin
                if (req != 3'b000) begin
                    m_state = 1; m_cur = modelLowest(req); m_dwell = 0;
                end
            end else if (m_state == 1) begin
                if (req == 3'b000) begin
                    m_state = 0;
                end else if (!req[m_cur] || next_btn || m_dwell == DWELL - 1) begin
                    m_cur = modelNext(req, m_cur); m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end else begin
                if (m_acnt == ALERTC - 1) begin
                    m_dwell = 0;
                    if (req[m_cur]) m_state = 1;
                    else if (req != 3'b000) begin m_state = 1; m_cur = modelNext(req, m_cur); end
                    else m_state = 0;
                end else begin
                    m_acnt++;
                    if (m_bcnt == BLINK - 1) begin m_bcnt = 0; m_on = !m_on; end
                    else m_bcnt++;
                end
            end
        end
        e.upper = m_half;
        if (m_state == 0) begin
            e.digits = 24'hFFFFFF; e.src = 2'd3; e.alert = 1'b0;
        end else if (m_state == 1) begin
            e.src = 2'(m_cur); e.alert = 1'b0;
            e.digits = (m_cur == 0) ? src0_digits : (m_cur == 1) ? src1_digits : src2_digits;
        end else begin
            e.src = 2'(m_cur); e.alert = 1'b1;
            e.digits = m_on ? m_msg : 24'hFFFFFF;
        end
    endtask

    // Runs n clocks with the current inputs: predict, push, clock, pop, compare.
    task automatic applyStimulus(input int n);
        exp_t e;
        exp_t got;
        for (int k = 0; k < n; k++) begin
            modelStep(e);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            checkOutput("sb_digits", 32'(dut_digits), 32'(got.digits));
            checkOutput("sb_active_src", 32'(active_src), 32'(got.src));
            checkOutput("sb_alert_active", 32'(alert_active), 32'(got.alert));
            checkOutput("sb_showUpperBits", 32'(showUpperBits), 32'(got.upper));
        end
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; next_btn = 1'b0; half_btn = 1'b0; alert_req = 1'b0;
        src0_digits = '0; src1_digits = '0; src2_digits = '0; alert_digits = '0;

        // Reset state
        applyStimulus(2);
        checkOutput("rst_digits", 32'(dut_digits), 32'h00FFFFFF);
        checkOutput("rst_src", 32'(active_src), 32'd3);
        checkOutput("rst_upper", 32'(showUpperBits), 32'd0);

        // Rotation between player and timer
        rst = 1'b0; req = 3'b101;
        src0_digits = 24'h000021; src1_digits = 24'h000019; src2_digits = 24'h001530;
        applyStimulus(1);
        checkOutput("rot_first_src", 32'(active_src), 32'd0);
        checkOutput("rot_first_d0", 32'(digit0), 32'd1);
        checkOutput("rot_first_d1", 32'(digit1), 32'd2);
        applyStimulus(7);
        checkOutput("rot_dwell_hold", 32'(active_src), 32'd0);
        applyStimulus(1);
        checkOutput("rot_to_timer", 32'(active_src), 32'd2);
        checkOutput("rot_timer_d0", 32'(digit0), 32'd0);
        checkOutput("rot_timer_d1", 32'(digit1), 32'd3);
        applyStimulus(8);
        checkOutput("rot_back_player", 32'(active_src), 32'd0);

        // Player/dealer with manual next and a dropped request
        req = 3'b011;
        applyStimulus(8);
        checkOutput("rr_to_dealer", 32'(active_src), 32'd1);
        applyStimulus(3);
        next_btn = 1'b1; applyStimulus(1); next_btn = 1'b0;
        checkOutput("next_btn_adv", 32'(active_src), 32'd0);
        applyStimulus(7);
        checkOutput("next_dwell_restart", 32'(active_src), 32'd0);
        applyStimulus(1);
        checkOutput("next_dwell_expire", 32'(active_src), 32'd1);
        next_btn = 1'b1; applyStimulus(1); next_btn = 1'b0;
        req = 3'b010; applyStimulus(1);
        checkOutput("drop_req_cur", 32'(active_src), 32'd1);
        applyStimulus(12);
        checkOutput("sole_requester", 32'(active_src), 32'd1);

        // next_btn coinciding with dwell expiry, plus a half toggle
        req = 3'b111; applyStimulus(3);
        next_btn = 1'b1; half_btn = 1'b1; applyStimulus(1); next_btn = 1'b0; half_btn = 1'b0;
        checkOutput("single_advance", 32'(active_src), 32'd2);
        checkOutput("half_first", 32'(showUpperBits), 32'd1);
        req = 3'b010; applyStimulus(1);
        checkOutput("back_to_dealer", 32'(active_src), 32'd1);

        // Alert pre-empting the dealer display
        alert_digits = 24'hB0A5EF; alert_req = 1'b1; applyStimulus(1);
        alert_req = 1'b0; alert_digits = 24'h123456;
        checkOutput("alert_on", 32'(alert_active), 32'd1);
        checkOutput("alert_msg", 32'(dut_digits), 32'h00B0A5EF);
        checkOutput("alert_saved_src", 32'(active_src), 32'd1);
        applyStimulus(3);
        checkOutput("alert_msg_hold", 32'(dut_digits), 32'h00B0A5EF);
        applyStimulus(1);
        checkOutput("alert_blank", 32'(dut_digits), 32'h00FFFFFF);
        half_btn = 1'b1; applyStimulus(1); half_btn = 1'b0;
        applyStimulus(3);
        checkOutput("alert_msg_again", 32'(dut_digits), 32'h00B0A5EF);
        checkOutput("half_second", 32'(showUpperBits), 32'd0);
        applyStimulus(7);
        checkOutput("alert_last_cycle", 32'(alert_active), 32'd1);
        applyStimulus(1);
        checkOutput("alert_done", 32'(alert_active), 32'd0);
        checkOutput("alert_return_src", 32'(active_src), 32'd1);

        // Re-triggered alert, next_btn ignored meanwhile
        alert_digits = 24'hAAAAAA; alert_req = 1'b1; applyStimulus(1); alert_req = 1'b0;
        next_btn = 1'b1; applyStimulus(1); next_btn = 1'b0;
        checkOutput("alert_ignores_next", 32'(active_src), 32'd1);
        applyStimulus(8);
        alert_digits = 24'h0C0DE0; alert_req = 1'b1; half_btn = 1'b1; applyStimulus(1);
        alert_req = 1'b0; half_btn = 1'b0;
        checkOutput("realert_msg", 32'(dut_digits), 32'h000C0DE0);
        checkOutput("half_third", 32'(showUpperBits), 32'd1);
        applyStimulus(15);
        checkOutput("realert_still_on", 32'(alert_active), 32'd1);
        applyStimulus(1);
        checkOutput("realert_done", 32'(alert_active), 32'd0);
        checkOutput("realert_src", 32'(active_src), 32'd1);

        // Alert and next_btn together, then reset mid-alert
        alert_digits = 24'h777777; alert_req = 1'b1; next_btn = 1'b1; applyStimulus(1);
        alert_req = 1'b0; next_btn = 1'b0;
        checkOutput("alert_wins_src", 32'(active_src), 32'd1);
        checkOutput("alert_wins_flag", 32'(alert_active), 32'd1);
        applyStimulus(8);
        rst = 1'b1; applyStimulus(1); rst = 1'b0;
        checkOutput("midrst_digits", 32'(dut_digits), 32'h00FFFFFF);
        checkOutput("midrst_src", 32'(active_src), 32'd3);
        checkOutput("midrst_alert", 32'(alert_active), 32'd0);
        checkOutput("midrst_upper", 32'(showUpperBits), 32'd0);

        // Alert exit when the saved source stopped requesting
        req = 3'b010; applyStimulus(2);
        alert_digits = 24'h5A5A5A; alert_req = 1'b1; applyStimulus(1); alert_req = 1'b0;
        req = 3'b100; applyStimulus(16);
        checkOutput("exit_next_src", 32'(active_src), 32'd2);
        checkOutput("exit_next_flag", 32'(alert_active), 32'd0);

        // Alert exit with nothing requesting falls back to idle
        alert_req = 1'b1; applyStimulus(1); alert_req = 1'b0;
        req = 3'b000; applyStimulus(16);
        checkOutput("exit_idle_src", 32'(active_src), 32'd3);
        checkOutput("exit_idle_digits", 32'(dut_digits), 32'h00FFFFFF);

        // Live re-sampling of the selected source
        req = 3'b001;
        for (int k = 0; k < 12; k++) begin
            src0_digits = 24'($urandom);
            applyStimulus(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
